stack_param: RTL and testbench

//   Parametrised LIFO stack with registered read port: push, pop and indexed
//   get (peek at depth INDEX below top). Generalises the fixed 4-bit x 5-entry

---
 rtl/stack_param.sv | 129 ++++++++++++
 tb/tb_stack_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/stack_param.sv
// stack_param: parametrised LIFO operand stack with a registered read port.
//   Push writes at SP, pop reads the top and retreats SP, get peeks INDEX
//   entries below the top. Pointer arithmetic is modulo DEPTH, so DEPTH
//   need not be a power of two.
//   MODE 0 (circular): push on full overwrites the oldest entry, and pop on
//     empty still retreats SP and shows stale data. ERROR is never set.
//   MODE 1 (guarded): commands that would overflow, underflow or read past
//     COUNT are rejected, leave state and O_DATA unchanged, and raise ERROR
//     for one cycle.
// Ports:
//   CLK      clock, rising edge
//   RESET    asynchronous active-high reset
//   COMMAND  00 nop, 01 push, 10 pop, 11 get
//   INDEX    get depth below top (0 = top)
//   I_DATA   push data
//   O_DATA   registered pop/get data
//   O_VALID  O_DATA came from a live entry
//   FULL     COUNT == DEPTH
//   EMPTY    COUNT == 0
//   COUNT    number of live entries
//   ERROR    registered; high the cycle after a rejected command
module stack_param #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 5,
  parameter int unsigned IW    = 3,
  parameter int unsigned MODE  = 0
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [1:0]                   COMMAND,
  input  logic [IW-1:0]                INDEX,
  input  logic [WIDTH-1:0]             I_DATA,
  output logic [WIDTH-1:0]             O_DATA,
  output logic                         O_VALID,
  output logic                         FULL,
  output logic                         EMPTY,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT,
  output logic                         ERROR
);

  localparam int unsigned SPW     = $clog2(DEPTH);
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam bit          GUARDED = (MODE != 0);

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_e;

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [SPW-1:0]   sp;

  cmd_e             cmd;
  logic [SPW-1:0]   top_idx;
  logic [SPW-1:0]   next_sp;
  logic [SPW-1:0]   get_idx;
  logic             get_live;
  logic [31:0]      k_w;
  logic [31:0]      addr_w;

  assign FULL  = (COUNT == CW'(DEPTH));
  assign EMPTY = (COUNT == '0);

  always_comb begin
    cmd      = cmd_e'(COMMAND);
    top_idx  = (sp == '0) ? SPW'(DEPTH - 1) : sp - 1'b1;
    next_sp  = (sp == SPW'(DEPTH - 1)) ? '0 : sp + 1'b1;
    // Reduce INDEX mod DEPTH first so sp + DEPTH - 1 - k never underflows.
    k_w      = 32'(INDEX) % DEPTH;
    addr_w   = (32'(sp) + DEPTH - 32'd1 - k_w) % DEPTH;
    get_idx  = SPW'(addr_w);
    // Liveness uses the raw INDEX, so an aliased index still reads as stale.
    get_live = (32'(INDEX) < 32'(COUNT));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sp      <= '0;
      COUNT   <= '0;
      O_DATA  <= '0;
      O_VALID <= 1'b0;
      ERROR   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (cmd)
        CMD_PUSH: begin
          if (GUARDED && FULL) begin
            ERROR <= 1'b1;
          end else begin
            mem[sp] <= I_DATA;
            sp      <= next_sp;
            if (!FULL) COUNT <= COUNT + 1'b1;
            ERROR   <= 1'b0;
          end
        end
        CMD_POP: begin
          if (GUARDED && EMPTY) begin
            O_VALID <= 1'b0;
            ERROR   <= 1'b1;
          end else begin
            O_DATA  <= mem[top_idx];
            O_VALID <= !EMPTY;
            sp      <= top_idx;
            if (!EMPTY) COUNT <= COUNT - 1'b1;
            ERROR   <= 1'b0;
          end
        end
        CMD_GET: begin
          if (GUARDED && !get_live) begin
            O_VALID <= 1'b0;
            ERROR   <= 1'b1;
          end else begin
            O_DATA  <= mem[get_idx];
            O_VALID <= get_live;
            ERROR   <= 1'b0;
          end
        end
        default: begin
          ERROR <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_param.sv
// Directed bench for stack_param: one circular (MODE 0) and one guarded
// (MODE 1) instance share the same stimulus; each step checks the instance
// whose behaviour the step is about against hand-computed values.
module tb_stack_param;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] GET  = 2'b11;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [1:0] COMMAND = NOP;
  logic [2:0] INDEX = '0;
  logic [3:0] I_DATA = '0;

  logic [3:0] d0_data, d1_data;
  logic       d0_valid, d1_valid, d0_full, d1_full, d0_empty, d1_empty;
  logic       d0_err, d1_err;
  logic [2:0] d0_count, d1_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  stack_param #(.WIDTH(4), .DEPTH(5), .IW(3), .MODE(0)) u_circ (
    .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND), .INDEX(INDEX), .I_DATA(I_DATA),
    .O_DATA(d0_data), .O_VALID(d0_valid), .FULL(d0_full), .EMPTY(d0_empty),
    .COUNT(d0_count), .ERROR(d0_err)
  );

  stack_param #(.WIDTH(4), .DEPTH(5), .IW(3), .MODE(1)) u_guard (
    .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND), .INDEX(INDEX), .I_DATA(I_DATA),
    .O_DATA(d1_data), .O_VALID(d1_valid), .FULL(d1_full), .EMPTY(d1_empty),
    .COUNT(d1_count), .ERROR(d1_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one command for exactly one edge; sample 1 time unit after it.
  task automatic do_cmd(input logic [1:0] c, input logic [2:0] idx, input logic [3:0] d);
    @(negedge CLK);
    COMMAND = c;
    INDEX   = idx;
    I_DATA  = d;
    @(posedge CLK);
    #1;
    COMMAND = NOP;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_data",  32'(d0_data),  32'h0);
    check("rst_valid", 32'(d0_valid), 32'h0);
    check("rst_count", 32'(d0_count), 32'h0);
    check("rst_empty", 32'(d0_empty), 32'h1);
    check("rst_full",  32'(d0_full),  32'h0);
    check("rst_err",   32'(d1_err),   32'h0);

    // 1: push 1, 3; get 0,1,2
    do_cmd(PUSH, 3'd0, 4'h1);
    do_cmd(PUSH, 3'd0, 4'h3);
    do_cmd(GET, 3'd0, 4'h0);
    check("t1_get0_data",  32'(d0_data),  32'h3);
    check("t1_get0_valid", 32'(d0_valid), 32'h1);
    do_cmd(GET, 3'd1, 4'h0);
    check("t1_get1_data",  32'(d0_data),  32'h1);
    check("t1_get1_valid", 32'(d0_valid), 32'h1);
    do_cmd(GET, 3'd2, 4'h0);
    check("t1_get2_valid", 32'(d0_valid), 32'h0);
    check("t1_count",      32'(d0_count), 32'h2);
    check("t1_g_get2_err",  32'(d1_err),  32'h1);
    check("t1_g_get2_hold", 32'(d1_data), 32'h1);
    check("t1_c_err",       32'(d0_err),  32'h0);

    // 2: circular overflow and underflow
    do_reset();
    for (int i = 1; i <= 7; i++) do_cmd(PUSH, 3'd0, 4'(i));
    check("t2_count_full", 32'(d0_count), 32'h5);
    check("t2_full",       32'(d0_full),  32'h1);
    check("t2_c_err",      32'(d0_err),   32'h0);
    for (int i = 7; i >= 3; i--) begin
      do_cmd(POP, 3'd0, 4'h0);
      check("t2_pop_data",  32'(d0_data),  32'(i));
      check("t2_pop_valid", 32'(d0_valid), 32'h1);
    end
    do_cmd(POP, 3'd0, 4'h0);
    check("t2_pop6_data",  32'(d0_data),  32'h7);
    check("t2_pop6_valid", 32'(d0_valid), 32'h0);
    check("t2_empty",      32'(d0_empty), 32'h1);
    check("t2_count0",     32'(d0_count), 32'h0);

    // 3: guarded overflow and underflow
    do_reset();
    for (int i = 1; i <= 5; i++) do_cmd(PUSH, 3'd0, 4'(i));
    check("t3_err_before", 32'(d1_err), 32'h0);
    do_cmd(PUSH, 3'd0, 4'h6);
    check("t3_ovf_err",   32'(d1_err),   32'h1);
    check("t3_ovf_count", 32'(d1_count), 32'h5);
    do_cmd(GET, 3'd0, 4'h0);
    check("t3_err_clear", 32'(d1_err),  32'h0);
    check("t3_get0",      32'(d1_data), 32'h5);
    for (int i = 5; i >= 1; i--) begin
      do_cmd(POP, 3'd0, 4'h0);
      check("t3_pop_data", 32'(d1_data), 32'(i));
    end
    do_cmd(POP, 3'd0, 4'h0);
    check("t3_unf_err",   32'(d1_err),   32'h1);
    check("t3_unf_hold",  32'(d1_data),  32'h1);
    check("t3_unf_valid", 32'(d1_valid), 32'h0);
    check("t3_unf_count", 32'(d1_count), 32'h0);
    do_cmd(NOP, 3'd0, 4'h0);
    check("t3_err_one_cycle", 32'(d1_err), 32'h0);

    // 4: out-of-range INDEX aliases mod DEPTH
    do_reset();
    for (int i = 1; i <= 5; i++) do_cmd(PUSH, 3'd0, 4'(i));
    do_cmd(GET, 3'd6, 4'h0);
    check("t4_idx6_data",  32'(d0_data),  32'h4);
    check("t4_idx6_valid", 32'(d0_valid), 32'h0);
    check("t4_g_idx6_err", 32'(d1_err),   32'h1);
    do_cmd(GET, 3'd4, 4'h0);
    check("t4_idx4_data",  32'(d0_data),  32'h1);
    check("t4_idx4_valid", 32'(d0_valid), 32'h1);
    check("t4_g_idx4",     32'(d1_data),  32'h1);

    // 5: asynchronous reset during a pop stream
    do_reset();
    for (int i = 1; i <= 3; i++) do_cmd(PUSH, 3'd0, 4'(i));
    do_cmd(POP, 3'd0, 4'h0);
    check("t5_pop", 32'(d0_data), 32'h3);
    @(negedge CLK);
    COMMAND = POP;
    #1 RESET = 1'b1;
    #1;
    check("t5_async_data",  32'(d0_data),  32'h0);
    check("t5_async_count", 32'(d0_count), 32'h0);
    #1 RESET = 1'b0;
    @(posedge CLK);
    #1;
    COMMAND = NOP;
    check("t5_next_data",  32'(d0_data),  32'h0);
    check("t5_next_valid", 32'(d0_valid), 32'h0);

    // 6: nop holds outputs; get latency is one edge
    do_reset();
    do_cmd(PUSH, 3'd0, 4'h6);
    for (int i = 0; i < 3; i++) begin
      do_cmd(NOP, 3'd0, 4'h0);
      check("t6_nop_data",  32'(d0_data),  32'h0);
      check("t6_nop_valid", 32'(d0_valid), 32'h0);
    end
    @(negedge CLK);
    COMMAND = GET;
    INDEX   = 3'd0;
    #1;
    check("t6_pre_edge", 32'(d0_data), 32'h0);
    @(posedge CLK);
    #1;
    COMMAND = NOP;
    check("t6_get_data",  32'(d0_data),  32'h6);
    check("t6_get_valid", 32'(d0_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
